// File: rtl/field_wr_addr_gen.sv
// Frame-buffer write address generator for interlaced video: odd field lines land on even
// buffer rows, even field lines on odd rows, so one odd+even pair forms an interleaved frame.
module field_wr_addr_gen #(
  parameter int unsigned H_ACT = 720,
  parameter int unsigned V_ACT = 288,
  parameter int unsigned AW    = 20
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          odd_field_tri,
  input  logic          even_field_tri,
  input  logic          de_in,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          field_id,
  output logic          frame_done,
  output logic          field_err
);

  localparam int unsigned PW = $clog2(H_ACT + 1);
  localparam int unsigned LW = $clog2(V_ACT + 1);

  localparam logic [PW-1:0] PixMax   = PW'(H_ACT);
  localparam logic [LW-1:0] LineMax  = LW'(V_ACT);
  localparam logic [AW-1:0] EvenBase = AW'(H_ACT);
  localparam logic [AW-1:0] LineStep = AW'(2 * H_ACT);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e          state_q, state_d;
  logic            field_id_q, field_id_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [AW-1:0]   line_base_q, line_base_d;
  logic            de_q, de_d;
  logic            skip_q, skip_d;
  logic            odd_done_q, odd_done_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            frame_done_q, frame_done_d;
  logic            field_err_q, field_err_d;

  logic odd_only, even_only, both_tri;

  assign odd_only  = odd_field_tri & ~even_field_tri;
  assign even_only = even_field_tri & ~odd_field_tri;
  assign both_tri  = odd_field_tri & even_field_tri;

  always_comb begin
    state_d      = state_q;
    field_id_d   = field_id_q;
    line_cnt_d   = line_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    line_base_d  = line_base_q;
    de_d         = 1'b0;
    skip_d       = skip_q;
    odd_done_d   = odd_done_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    field_err_d  = 1'b0;

    if (both_tri) begin
      state_d     = StIdle;
      field_err_d = 1'b1;
      odd_done_d  = 1'b0;
      skip_d      = 1'b0;
    end else if (odd_only || even_only) begin
      // A restart while still collecting lines means the previous field was truncated.
      if (state_q == StActive) begin
        field_err_d = 1'b1;
        odd_done_d  = 1'b0;
      end
      state_d     = StActive;
      field_id_d  = even_only;
      line_cnt_d  = '0;
      pix_cnt_d   = '0;
      line_base_d = even_only ? EvenBase : '0;
      // A line already in progress at the trigger is discarded until de_in drops.
      skip_d      = de_in;
    end else if (state_q == StActive) begin
      if (skip_q) begin
        skip_d = de_in;
      end else begin
        de_d = de_in;
        if (de_in) begin
          if (pix_cnt_q < PixMax) begin
            wr_en_d   = 1'b1;
            wr_addr_d = line_base_q + AW'(pix_cnt_q);
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (de_q) begin
          pix_cnt_d   = '0;
          line_cnt_d  = line_cnt_q + 1'b1;
          line_base_d = line_base_q + LineStep;
          if (line_cnt_q == LineMax - 1'b1) begin
            state_d = StDone;
            if (field_id_q) begin
              frame_done_d = odd_done_q;
              odd_done_d   = 1'b0;
            end else begin
              odd_done_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      field_id_q   <= 1'b0;
      line_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      line_base_q  <= '0;
      de_q         <= 1'b0;
      skip_q       <= 1'b0;
      odd_done_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      field_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_id_q   <= field_id_d;
      line_cnt_q   <= line_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      line_base_q  <= line_base_d;
      de_q         <= de_d;
      skip_q       <= skip_d;
      odd_done_q   <= odd_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      field_err_q  <= field_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign field_id   = field_id_q;
  assign frame_done = frame_done_q;
  assign field_err  = field_err_q;

endmodule

// File: tb/tb_field_wr_addr_gen.sv
// Directed bench for field_wr_addr_gen with a tiny 4-pixel x 2-line field.
module tb_field_wr_addr_gen;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          odd = 1'b0;
  logic          even = 1'b0;
  logic          de = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          field_id;
  logic          frame_done;
  logic          field_err;

  int n_cmp = 0;
  int n_err = 0;

  field_wr_addr_gen #(
    .H_ACT (H),
    .V_ACT (V),
    .AW    (AW)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .odd_field_tri  (odd),
    .even_field_tri (even),
    .de_in          (de),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .field_id       (field_id),
    .frame_done     (frame_done),
    .field_err      (field_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic o, input logic e, input logic d);
    odd  = o;
    even = e;
    de   = d;
    tick();
    odd  = 1'b0;
    even = 1'b0;
  endtask

  // Drives one line of npix pixels then de low; pixels past H must be dropped.
  task automatic drive_line(input int npix, input int base, input string tag);
    logic [AW-1:0] exp_a;
    for (int i = 0; i < npix; i++) begin
      de = 1'b1;
      tick();
      exp_a = AW'(base + i);
      n_cmp++;
      if (i < H) begin
        if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
          n_err++;
          $display("FAIL %s pix%0d: wr_en=%b wr_addr=%0d, want wr_en=1 wr_addr=%0d",
                   tag, i, wr_en, wr_addr, exp_a);
        end
      end else if (wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s drop%0d: wr_en=%b, want 0", tag, i, wr_en);
      end
    end
    de = 1'b0;
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s line_end: wr_en=%b, want 0", tag, wr_en);
    end
  endtask

  task automatic no_writes(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      tick();
      n_cmp++;
      if (wr_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s cyc%0d: wr_en=%b, want 0", tag, i, wr_en);
      end
    end
    de = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({wr_en, wr_addr, field_id, frame_done, field_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b addr=%0d fid=%b fd=%b err=%b, want all 0",
               wr_en, wr_addr, field_id, frame_done, field_err);
    end
    rst_n = 1'b1;
    no_writes(2, "idle_after_reset");
  endtask

  task automatic test_odd_field();
    trig(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (field_id !== 1'b0 || field_err !== 1'b0) begin
      n_err++;
      $display("FAIL odd_start: fid=%b err=%b, want 0 0", field_id, field_err);
    end
    drive_line(4, 0, "odd_l0");
    drive_line(4, 8, "odd_l1");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL odd_no_frame_done: frame_done=%b, want 0", frame_done);
    end
    no_writes(3, "done_ignores_de");
  endtask

  task automatic test_even_field();
    trig(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (field_id !== 1'b1) begin
      n_err++;
      $display("FAIL even_start: fid=%b, want 1", field_id);
    end
    drive_line(4, 4, "even_l0");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL even_mid_frame_done: frame_done=%b, want 0", frame_done);
    end
    drive_line(4, 12, "even_l1");
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL frame_done_pulse: frame_done=%b, want 1", frame_done);
    end
    tick();
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL frame_done_single: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_overlong_line();
    trig(1'b1, 1'b0, 1'b0);
    drive_line(6, 0, "long_l0");
    drive_line(4, 8, "long_l1");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL long_frame_done: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_restart();
    trig(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (field_err !== 1'b0) begin
      n_err++;
      $display("FAIL start_from_done_err: field_err=%b, want 0", field_err);
    end
    drive_line(4, 0, "rst_l0");
    trig(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (field_err !== 1'b1 || field_id !== 1'b0) begin
      n_err++;
      $display("FAIL restart_err: err=%b fid=%b, want 1 0", field_err, field_id);
    end
    tick();
    n_cmp++;
    if (field_err !== 1'b0) begin
      n_err++;
      $display("FAIL restart_err_pulse: field_err=%b, want 0", field_err);
    end
    drive_line(4, 0, "restart_l0");
    drive_line(4, 8, "restart_l1");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_frame_done: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_both_triggers();
    trig(1'b0, 1'b1, 1'b0);
    drive_line(4, 4, "both_pre");
    trig(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (field_err !== 1'b1 || field_id !== 1'b1) begin
      n_err++;
      $display("FAIL both_err: err=%b fid=%b, want 1 1", field_err, field_id);
    end
    no_writes(4, "both_idle");
    trig(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (field_err !== 1'b0 || field_id !== 1'b1) begin
      n_err++;
      $display("FAIL after_both_start: err=%b fid=%b, want 0 1", field_err, field_id);
    end
    drive_line(4, 4, "after_both_l0");
    drive_line(4, 12, "after_both_l1");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL after_err_frame_done: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_de_at_trigger();
    trig(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL de_at_trig: wr_en=%b, want 0", wr_en);
    end
    tick();
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL de_held_after_trig: wr_en=%b, want 0", wr_en);
    end
    de = 1'b0;
    tick();
    drive_line(4, 0, "skip_l0");
    drive_line(4, 8, "skip_l1");
    no_writes(2, "skip_done");
  endtask

  task automatic test_reset_mid_line();
    trig(1'b1, 1'b0, 1'b0);
    drive_line(4, 0, "pre_rst_l0");
    drive_line(4, 8, "pre_rst_l1");
    trig(1'b0, 1'b1, 1'b0);
    de = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 8'd5) begin
      n_err++;
      $display("FAIL pre_rst_write: en=%b addr=%0d, want 1 5", wr_en, wr_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, field_id, frame_done, field_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: en=%b addr=%0d fid=%b fd=%b err=%b, want all 0",
               wr_en, wr_addr, field_id, frame_done, field_err);
    end
    tick();
    rst_n = 1'b1;
    no_writes(3, "post_rst_idle");
    trig(1'b0, 1'b1, 1'b0);
    drive_line(4, 4, "post_rst_l0");
    drive_line(4, 12, "post_rst_l1");
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst_frame_done: frame_done=%b, want 0", frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_odd_field();
    test_even_field();
    test_overlong_line();
    test_restart();
    test_both_triggers();
    test_de_at_trigger();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/field_wr_addr_gen.md
FIELD_WR_ADDR_GEN -- requirements
Module: field_wr_addr_gen

Interface
REQ-001 The block SHALL have parameter H_ACT, default 720, meaning active pixels stored per line.
REQ-002 The block SHALL have parameter V_ACT, default 288, meaning active lines stored per field.
REQ-003 The block SHALL have parameter AW, default 20, meaning write address width; 2*V_ACT*H_ACT SHALL not exceed 2^AW.
REQ-004 Port clk_in, input, 1 bit: single clock, rising edge; all logic SHALL be in this domain.
REQ-005 Port rst_n_in, input, 1 bit: asynchronous active-low reset.
REQ-006 Port odd_field_tri, input, 1 bit: one-cycle pulse at the start of an odd field.
REQ-007 Port even_field_tri, input, 1 bit: one-cycle pulse at the start of an even field.
REQ-008 Port de_in, input, 1 bit: active-video pixel valid, high for the duration of each line's pixels.
REQ-009 Port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-010 Port wr_addr, output, AW bits: frame-buffer write address, valid when wr_en=1.
REQ-011 Port field_id, output, 1 bit: current field, 0=odd, 1=even.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse when a full interleaved frame has been written.
REQ-013 Port field_err, output, 1 bit: one-cycle pulse on a truncated or ambiguous field start.

Function
REQ-014 The block SHALL implement states IDLE, ACTIVE and DONE; after reset it SHALL be in IDLE, and IDLE/DONE SHALL produce no writes.
REQ-015 On odd_field_tri=1 with even_field_tri=0, the block SHALL, from any state, enter ACTIVE with field_id=0, line_cnt=0, pix_cnt=0, line_base=0.
REQ-016 On even_field_tri=1 with odd_field_tri=0, the block SHALL, from any state, enter ACTIVE with field_id=1, line_cnt=0, pix_cnt=0, line_base=H_ACT.
REQ-017 If both triggers are 1 in the same cycle, the block SHALL pulse field_err, go to IDLE and leave field_id unchanged.
REQ-018 A trigger arriving in ACTIVE before line_cnt reaches V_ACT SHALL pulse field_err in the cycle after the trigger and still restart per REQ-015/REQ-016.
REQ-019 In ACTIVE, each cycle with de_in=1 and pix_cnt<H_ACT SHALL produce, one cycle later, wr_en=1 and wr_addr=line_base+pix_cnt, then increment pix_cnt.
REQ-020 Pixels with pix_cnt>=H_ACT SHALL be dropped (wr_en=0) and pix_cnt SHALL saturate.
REQ-021 A falling edge of de_in (registered de_in=1, de_in=0) in ACTIVE SHALL end the line: pix_cnt<=0, line_cnt+1, line_base+2*H_ACT; the block SHALL use add-only address generation with no multiplier.
REQ-022 Short lines (fewer than H_ACT pixels) SHALL still advance line_cnt; remaining addresses of that line SHALL be left unwritten.
REQ-023 When line_cnt reaches V_ACT, the block SHALL enter DONE and ignore further de_in until the next trigger.
REQ-024 frame_done SHALL pulse exactly once, in the cycle after the ACTIVE->DONE transition, only when field_id=1 and the preceding completed field was odd (field_id=0) with no error in between.
REQ-025 If de_in=1 in the same cycle as a trigger, that pixel SHALL be discarded and the line SHALL begin at the next de_in rising edge.
REQ-026 wr_en, wr_addr, frame_done and field_err SHALL all be registered outputs.

Reset
REQ-027 On rst_n_in=0, the block SHALL immediately and asynchronously set state=IDLE, wr_en=0, wr_addr=0, field_id=0, frame_done=0, field_err=0, all counters=0, and clear the odd-complete flag.
REQ-028 Reset assertion mid-line SHALL abort the line with no further writes until a new trigger follows reset release.
REQ-029 Reset release SHALL be used synchronously; the first cycle after release SHALL be in IDLE.

Verification
REQ-030 H_ACT=4, V_ACT=2: odd_field_tri, then two lines of de_in=1 for 4 cycles each -> wr_addr sequence 0,1,2,3,8,9,10,11, with wr_en 1 cycle after de_in, and state ending in DONE.
REQ-031 Same parameters, then even_field_tri and two 4-pixel lines -> wr_addr 4,5,6,7,12,13,14,15, then one frame_done pulse.
REQ-032 de_in=1 for 6 cycles with H_ACT=4 -> only 4 writes, and the next line starts at line_base+8.
REQ-033 odd_field_tri after one line of a 2-line field -> field_err pulse, addresses restart at 0, and no frame_done for that frame.
REQ-034 odd_field_tri and even_field_tri together -> field_err=1, state=IDLE, and no writes until the next single trigger.
REQ-035 rst_n_in=0 asserted mid-line in an even field -> all outputs 0 immediately; after release, even field completion alone -> no frame_done.
